cdc_pulse_arb: RTL and testbench
================================

CDC_PULSE_ARB -- requirements
Module: cdc_pulse_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, the number of requesters sharing one cdc_s2f_pulse source port (range 2..8).
REQ-002 SHALL have parameter DW, default 32, the payload width.
REQ-003 SHALL have parameter GAP, default 2, the idle source cycles enforced after each pulse (range 0..15).
REQ-004 SHALL have port clk  in  1  single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester request.
REQ-007 SHALL have port req_data  in  NREQ*DW  flattened payloads; requester i occupies bits [i*DW +: DW].
REQ-008 SHALL have port req_ready  out  NREQ  per-requester one-cycle grant/accept strobe.
REQ-009 SHALL have port cdc_en  out  1  pulse to the CDC src_en.
REQ-010 SHALL have port cdc_data  out  DW  payload to the CDC src_in.
REQ-011 SHALL have port cdc_id  out  clog2(NREQ)  index of the granted requester, valid with cdc_en.
REQ-012 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SEND and GAP, with state held in registers.
REQ-014 In IDLE with any req_valid set, SHALL pick grant g as the first set bit at or after rr_ptr, searching upward with wrap modulo NREQ.
REQ-015 In that same IDLE cycle, SHALL assert req_ready[g] combinationally, register req_data[g] and g, load rr_ptr with (g+1) mod NREQ, and go to SEND.
REQ-016 SHALL assert req_ready on at most one bit, and only in IDLE; req_ready SHALL be all zero in SEND and GAP.
REQ-017 In SEND, SHALL drive cdc_en=1 for exactly one cycle with the captured cdc_data and cdc_id.
REQ-018 SHALL hold cdc_data and cdc_id at 0 whenever cdc_en=0.
REQ-019 From SEND, SHALL go to GAP if GAP>0, or to IDLE if GAP=0.
REQ-020 In GAP, SHALL count GAP cycles with a 4-bit down-counter, then return to IDLE.
REQ-021 Grant-to-pulse latency SHALL be 1 cycle; the minimum pulse spacing SHALL be 2+GAP cycles.
REQ-022 Requesters hold req_valid and req_data until req_ready. A req_valid dropped before grant SHALL be ignored without error, and no stale data SHALL be sent.
REQ-023 When requests arrive simultaneously, SHALL serve them strictly round-robin, with no requester starved while others stay asserted.
REQ-024 rr_ptr SHALL wrap from NREQ-1 to 0.
REQ-025 A req_valid rising during SEND or GAP SHALL be considered in the next IDLE cycle only.

Reset
REQ-026 On rstn low, SHALL immediately force state=IDLE, rr_ptr=0, gap counter=0, cdc_en=0, cdc_data=0, cdc_id=0, busy=0 and req_ready=0, asynchronously.
REQ-027 A reset during SEND or GAP SHALL abort the transfer; the captured payload is discarded and not re-sent.
REQ-028 Leaving reset SHALL synchronise to clk; the first grant can occur no earlier than the first rising edge with rstn high.

Structure
REQ-029 SHALL place the state encoding (IDLE=0, SEND=1, GAP=2) and the GAP counter width constant in shared package cdc_arb_pkg.
REQ-030 SHALL implement the wrap-around priority pick as sub-module rr_pick (inputs req and ptr; outputs gnt_onehot, gnt_idx, any).
REQ-031 SHALL contain no clock-domain crossing; it sits entirely in the src_clk domain of cdc_s2f_pulse.

Verification
REQ-032 The bench SHALL cover: single requester 1, data 0x11 -> req_ready[1] at T; cdc_en, cdc_data=0x11 and cdc_id=1 at T+1; busy high T+1..T+3; IDLE at T+4.
REQ-033 The bench SHALL cover: all four valid at once with data 0xA0..0xA3 -> pulses in order id 0,1,2,3, four cycles apart, each req_ready one cycle.
REQ-034 The bench SHALL cover wrap-around: after a grant to 3, requesters 0 and 3 valid -> 0 is served before 3.
REQ-035 The bench SHALL cover reset mid-transfer: rstn low during GAP -> all outputs 0 immediately, no further cdc_en, and after release a fresh request from requester 2 is granted first (rr_ptr=0 search).
REQ-036 The bench SHALL cover GAP=0 with requester 2 continuously valid -> cdc_en every 2 cycles and data matching each accepted payload.
REQ-037 The bench SHALL cover end-to-end delivery: the arbiter driving a cdc_s2f_pulse with 15 payloads 0x1..0xF from mixed requesters -> dest_en count is 15 and dest_out sequence matches grant order.

Source files
------------

// File: rtl/cdc_arb_pkg.sv
// ---------------------------------------------------------------------------
// cdc_arb_pkg
// Shared constants for the pulse arbiter that feeds a cdc_s2f_pulse source.
//   ST_IDLE / ST_SEND / ST_GAP : arbiter state encoding
//   GAP_CW                     : width of the idle-gap down-counter
// ---------------------------------------------------------------------------
package cdc_arb_pkg;

    // State encoding is kept as plain constants so older tools and any
    // external debug logic can decode the state register directly.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // A 4-bit counter covers the full 0..15 range of idle gap cycles.
    localparam int GAP_CW = 4;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Wrap-around priority picker: returns the first set request bit at or
// above ptr, searching upward and wrapping modulo N.
//   req        in  N   request vector
//   ptr        in  IW  index where the search starts
//   gnt_onehot out N   one-hot grant (zero when nothing is requested)
//   gnt_idx    out IW  binary index of the grant
//   any        out 1   at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Walk the N candidate positions starting at ptr; the first requester
    // found wins and later hits are ignored. The modulo keeps the search
    // correct for N values that are not a power of two.
    always_comb begin : pick
        int            idx;
        logic [IW-1:0] w_sel;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        w_sel      = '0;
        for (int k = 0; k < N; k++) begin
            idx   = (int'(ptr) + k) % N;
            w_sel = IW'(idx);
            if (!any && req[w_sel]) begin
                any        = 1'b1;
                gnt_idx    = w_sel;
                gnt_onehot = N'(1) << w_sel;
            end
        end
    end

endmodule

// File: rtl/cdc_pulse_arb.sv
// ---------------------------------------------------------------------------
// cdc_pulse_arb
// Round-robin arbiter that lets NREQ requesters share one cdc_s2f_pulse
// source port. A grant captures the payload, the next cycle emits a single
// cdc_en pulse, then GAP idle cycles give the synchroniser time to settle.
// Everything runs in the source clock domain.
//   clk        in  1        clock, rising edge
//   rstn       in  1        asynchronous active-low reset
//   req_valid  in  NREQ     per-requester request
//   req_data   in  NREQ*DW  flattened payloads, requester i at [i*DW +: DW]
//   req_ready  out NREQ     one-cycle accept strobe (combinational, IDLE only)
//   cdc_en     out 1        pulse to the CDC src_en
//   cdc_data   out DW       payload to the CDC src_in (0 when cdc_en is low)
//   cdc_id     out IW       granted requester index (0 when cdc_en is low)
//   busy       out 1        high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module cdc_pulse_arb
    import cdc_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int GAP  = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    cdc_en,
    output logic [DW-1:0]           cdc_data,
    output logic [$clog2(NREQ)-1:0] cdc_id,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);

    // The counter is loaded with GAP-1 on entry to ST_GAP, so it reaches
    // zero on the last gap cycle and the return to IDLE needs no extra
    // compare against GAP itself.
    localparam logic [GAP_CW-1:0] GAP_LOAD = (GAP > 0) ? GAP_CW'(GAP - 1) : '0;

    logic [1:0]        r_state;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_id;
    logic [DW-1:0]     r_data;
    logic [GAP_CW-1:0] r_gapCnt;

    logic [NREQ-1:0]   w_gntOnehot;
    logic [IW-1:0]     w_gntIdx;
    logic              w_any;
    logic              w_inIdle;
    logic              w_inSend;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req        (req_valid),
        .ptr        (r_ptr),
        .gnt_onehot (w_gntOnehot),
        .gnt_idx    (w_gntIdx),
        .any        (w_any)
    );

    assign w_inIdle = (r_state == ST_IDLE);
    assign w_inSend = (r_state == ST_SEND);

    // req_ready is gated by rstn so the strobe drops the instant reset is
    // applied, rather than waiting for the state register to settle.
    assign req_ready = (w_inIdle && rstn) ? w_gntOnehot : '0;
    assign cdc_en    = w_inSend;
    assign cdc_data  = w_inSend ? r_data : '0;
    assign cdc_id    = w_inSend ? r_id   : '0;
    assign busy      = !w_inIdle;

    // Main sequencer. IDLE captures the winner and advances the pointer to
    // the slot just past it so the winner has lowest priority next time.
    // SEND lasts exactly one cycle. GAP counts down before the next
    // arbitration. Reset clears the captured payload so an aborted
    // transfer can never be replayed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_data   <= '0;
            r_gapCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_SEND;
                        r_data  <= req_data[int'(w_gntIdx)*DW +: DW];
                        r_id    <= w_gntIdx;
                        r_ptr   <= (w_gntIdx == IW'(NREQ - 1)) ? '0 : w_gntIdx + IW'(1);
                    end
                end
                ST_SEND: begin
                    if (GAP == 0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state  <= ST_GAP;
                        r_gapCnt <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (r_gapCnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt - GAP_CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_pulse_arb.sv
// ---------------------------------------------------------------------------
// tb_cdc_pulse_arb
// Self-checking bench for cdc_pulse_arb. Instance A uses GAP=2, instance B
// uses GAP=0. A cycle-level behavioural model (last-grant time, pointer,
// captured payload) predicts every output on every falling edge. Directed
// scenarios pin literal expectations; randomised requesters exercise drops
// and contention; a small toggle-synchroniser model on a fast destination
// clock checks end-to-end delivery order.
// ---------------------------------------------------------------------------
module tb_cdc_pulse_arb;

    localparam int GAPA = 2;
    localparam int GAPB = 0;

    logic         clk = 1'b0;
    logic         dclk = 1'b0;
    logic         rstn;
    logic [3:0]   validA, validB, readyA, readyB;
    logic [127:0] dataA, dataB;
    logic         enA, enB, busyA, busyB;
    logic [31:0]  cdcDataA, cdcDataB;
    logic [1:0]   idA, idB;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    // Behavioural model state, one slot per DUT instance.
    int          mLast [2] = '{-1000, -1000};
    int          mPtr  [2] = '{0, 0};
    logic [31:0] mData [2] = '{32'h0, 32'h0};
    int          mId   [2] = '{0, 0};

    // End-to-end bookkeeping.
    bit          e2eOn = 1'b0;
    logic [31:0] grantQ[$];
    int          destCount = 0;
    int          deliveredSum = 0;
    int          nextPayload = 1;

    // Directed-run recording.
    int          nPulse;
    int          pId   [16];
    logic [31:0] pData [16];
    int          pCyc  [16];
    int          rdyCnt[4];

    always #5 clk = ~clk;
    always #2 dclk = ~dclk;

    cdc_pulse_arb #(.NREQ(4), .DW(32), .GAP(GAPA)) dutA (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (validA),
        .req_data  (dataA),
        .req_ready (readyA),
        .cdc_en    (enA),
        .cdc_data  (cdcDataA),
        .cdc_id    (idA),
        .busy      (busyA)
    );

    cdc_pulse_arb #(.NREQ(4), .DW(32), .GAP(GAPB)) dutB (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (validB),
        .req_data  (dataB),
        .req_ready (readyB),
        .cdc_en    (enB),
        .cdc_data  (cdcDataB),
        .cdc_id    (idB),
        .busy      (busyB)
    );

    // Single comparison point: every check funnels through here.
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s at t=%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    endtask

    task automatic failNow(input string name);
        nChecks++;
        $display("[TB] FAIL %s at t=%0t", name, $time);
    endtask

    // First requesting index at or after ptr, wrapping; -1 when none.
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Reference model: a grant can happen once 2+gap cycles have elapsed
    // since the previous grant; the pulse appears exactly one cycle after it.
    task automatic checkOutput(input int u, input int gap, input logic [3:0] v,
                               input logic [127:0] d, input logic [3:0] rdy,
                               input logic en, input logic [31:0] cd,
                               input logic [1:0] id, input logic bsy);
        logic [3:0]  expRdy;
        logic        expEn;
        logic        expBusy;
        logic [31:0] expData;
        logic [1:0]  expId;
        int          g;
        string       tag;
        tag     = (u == 0) ? "A" : "B";
        expRdy  = '0;
        expEn   = 1'b0;
        expBusy = 1'b0;
        expData = '0;
        expId   = '0;
        if (!rstn) begin
            mLast[u] = -1000;
            mPtr[u]  = 0;
        end else begin
            expEn   = (cyc == mLast[u] + 1);
            expBusy = (cyc < mLast[u] + 2 + gap);
            expData = expEn ? mData[u] : 32'h0;
            expId   = expEn ? 2'(mId[u]) : 2'd0;
            if (!expBusy) begin
                g = pick(v, mPtr[u]);
                if (g >= 0) begin
                    expRdy   = 4'(1) << g;
                    mLast[u] = cyc;
                    mPtr[u]  = (g + 1) % 4;
                    mData[u] = d[g*32 +: 32];
                    mId[u]   = g;
                    if (u == 0 && e2eOn) grantQ.push_back(d[g*32 +: 32]);
                end
            end
        end
        check({tag, " req_ready"}, rdy, expRdy);
        check({tag, " cdc_en"},    en,  expEn);
        check({tag, " cdc_data"},  cd,  expData);
        check({tag, " cdc_id"},    id,  expId);
        check({tag, " busy"},      bsy, expBusy);
    endtask

    // Compare process: outputs are sampled on the falling edge, half a
    // cycle away from the edge that updates the DUT.
    always @(negedge clk) begin
        cyc++;
        checkOutput(0, GAPA, validA, dataA, readyA, enA, cdcDataA, idA, busyA);
        checkOutput(1, GAPB, validB, dataB, readyB, enB, cdcDataB, idB, busyB);
    end

    // Behavioural toggle-synchroniser standing in for cdc_s2f_pulse: the
    // source flips a toggle and holds the payload, the fast destination
    // resynchronises the toggle and strobes dest_en on each change.
    logic        srcTog = 1'b0;
    logic [31:0] srcHold = '0;
    logic        s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic        destEn = 1'b0;
    logic [31:0] destOut = '0;

    always @(posedge clk) begin
        if (enA) begin
            srcTog  <= ~srcTog;
            srcHold <= cdcDataA;
        end
    end

    always @(posedge dclk) begin
        s1      <= srcTog;
        s2      <= s1;
        s3      <= s2;
        destEn  <= s2 ^ s3;
        destOut <= srcHold;
    end

    always @(negedge dclk) begin
        if (destEn && e2eOn) begin
            destCount++;
            deliveredSum += int'(destOut);
            if (grantQ.size() == 0) failNow("e2e dest_en with no pending grant");
            else check("e2e dest_out order", destOut, grantQ.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        tick();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Per-cycle requester behaviour for instance A. Mode 0: random raise,
    // random drop before grant, garbage data while idle. Mode 1: hand out
    // payloads 1..15 and never drop.
    task automatic applyStimulus(input logic [3:0] rdySeen, input int mode);
        for (int i = 0; i < 4; i++) begin
            if (rdySeen[i]) begin
                validA[i] = 1'b0;
            end else if (mode == 0) begin
                if (validA[i]) begin
                    if ($urandom_range(7) == 0) validA[i] = 1'b0;
                end else begin
                    dataA[i*32 +: 32] = $urandom;
                    if ($urandom_range(2) == 0) validA[i] = 1'b1;
                end
            end else begin
                if (!validA[i] && nextPayload <= 15 && $urandom_range(1) == 0) begin
                    validA[i]         = 1'b1;
                    dataA[i*32 +: 32] = 32'(nextPayload);
                    nextPayload++;
                end
            end
        end
    endtask

    // Runs instance A for n cycles, recording pulses and strobes; each
    // requester drops its valid the cycle after it is accepted.
    task automatic recordRunA(input int n);
        logic [3:0] rdySeen;
        nPulse = 0;
        for (int i = 0; i < 4; i++) rdyCnt[i] = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (readyA[i]) rdyCnt[i]++;
            if (enA && nPulse < 16) begin
                pId[nPulse]   = int'(idA);
                pData[nPulse] = cdcDataA;
                pCyc[nPulse]  = k;
                nPulse++;
            end
            rdySeen = readyA;
            tick();
            validA = validA & ~rdySeen;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0]  rdySeen;
        logic [31:0] lastAccepted;
        int          pulsesB;
        int          prevB;

        rstn   = 1'b1;
        validA = '0;
        validB = '0;
        dataA  = '0;
        dataB  = '0;
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", readyA, 4'b0000);
        check("reset cdc_en", enA, 1'b0);
        check("reset busy", busyA, 1'b0);

        // Single requester 1, payload 0x11.
        $display("[TB] single requester");
        rstn = 1'b1;
        validA[1] = 1'b1;
        dataA[63:32] = 32'h11;
        @(negedge clk);
        check("t1 req_ready at T", readyA, 4'b0010);
        tick();
        validA = '0;
        @(negedge clk);
        check("t1 cdc_en at T+1", enA, 1'b1);
        check("t1 cdc_data at T+1", cdcDataA, 32'h11);
        check("t1 cdc_id at T+1", idA, 2'd1);
        check("t1 busy at T+1", busyA, 1'b1);
        tick();
        @(negedge clk);
        check("t1 busy at T+2", busyA, 1'b1);
        check("t1 cdc_en at T+2", enA, 1'b0);
        check("t1 cdc_data at T+2", cdcDataA, 32'h0);
        tick();
        @(negedge clk);
        check("t1 busy at T+3", busyA, 1'b1);
        tick();
        @(negedge clk);
        check("t1 idle at T+4", busyA, 1'b0);
        tick();

        // All four at once after reset: served 0,1,2,3 four cycles apart.
        $display("[TB] four simultaneous requesters");
        doReset();
        validA = 4'b1111;
        dataA  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        recordRunA(18);
        check("t2 pulse count", nPulse, 4);
        for (int j = 0; j < 4; j++) begin
            check("t2 pulse id", pId[j], j);
            check("t2 pulse data", pData[j], 32'hA0 + 32'(j));
            check("t2 pulse cycle", pCyc[j], 1 + 4 * j);
            check("t2 ready strobes", rdyCnt[j], 1);
        end

        // Wrap-around: last grant was 3, so 0 beats 3.
        $display("[TB] pointer wrap");
        validA = 4'b1001;
        dataA  = {32'hB3, 32'h0, 32'h0, 32'hB0};
        recordRunA(12);
        check("t3 pulse count", nPulse, 2);
        check("t3 first id", pId[0], 0);
        check("t3 first data", pData[0], 32'hB0);
        check("t3 second id", pId[1], 3);
        check("t3 second data", pData[1], 32'hB3);
        check("t3 second cycle", pCyc[1], 5);

        // Reset while in GAP after granting 2 (pointer would be 3).
        $display("[TB] reset mid-transfer");
        validA = 4'b0100;
        dataA  = {32'h0, 32'hC2, 32'h0, 32'h0};
        @(negedge clk);
        check("t4 grant 2", readyA, 4'b0100);
        tick();
        validA = '0;
        @(negedge clk);
        check("t4 pulse", enA, 1'b1);
        tick();
        @(negedge clk);
        check("t4 in gap", busyA, 1'b1);
        #2;
        rstn   = 1'b0;
        validA = 4'b1000;
        dataA[127:96] = 32'hD3;
        #1;
        check("t4 rst req_ready", readyA, 4'b0000);
        check("t4 rst cdc_en", enA, 1'b0);
        check("t4 rst cdc_data", cdcDataA, 32'h0);
        check("t4 rst cdc_id", idA, 2'd0);
        check("t4 rst busy", busyA, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("t4 no cdc_en in reset", enA, 1'b0);
        end
        tick();
        rstn   = 1'b1;
        validA = 4'b1100;
        dataA  = {32'hE3, 32'hE2, 32'h0, 32'h0};
        recordRunA(12);
        check("t4 pulse count", nPulse, 2);
        check("t4 first id after reset", pId[0], 2);
        check("t4 first data", pData[0], 32'hE2);
        check("t4 first cycle", pCyc[0], 1);
        check("t4 second id", pId[1], 3);
        check("t4 second data", pData[1], 32'hE3);

        // GAP=0 instance with requester 2 always valid.
        $display("[TB] zero gap back-to-back");
        validB = 4'b0100;
        dataB[95:64] = $urandom;
        lastAccepted = 'x;
        pulsesB = 0;
        prevB = -10;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (enB) begin
                check("t5 B data", cdcDataB, lastAccepted);
                if (pulsesB > 0) check("t5 B spacing", k - prevB, 2);
                prevB = k;
                pulsesB++;
            end
            rdySeen = readyB;
            if (readyB[2]) lastAccepted = dataB[95:64];
            tick();
            if (rdySeen[2]) dataB[95:64] = $urandom;
        end
        check("t5 B pulse count", pulsesB, 10);
        validB = '0;
        repeat (4) tick();

        // Random contention with early drops; the model checks each cycle.
        $display("[TB] random requesters");
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            rdySeen = readyA;
            tick();
            applyStimulus(rdySeen, 0);
        end
        validA = '0;
        repeat (10) tick();

        // End-to-end through the synchroniser model.
        $display("[TB] end-to-end delivery");
        grantQ.delete();
        destCount    = 0;
        deliveredSum = 0;
        nextPayload  = 1;
        e2eOn        = 1'b1;
        for (int k = 0; k < 400 && !(nextPayload > 15 && validA == 4'b0000); k++) begin
            @(negedge clk);
            rdySeen = readyA;
            tick();
            applyStimulus(rdySeen, 1);
        end
        check("e2e all payloads issued", (nextPayload > 15 && validA == 4'b0000), 1'b1);
        repeat (15) tick();
        e2eOn = 1'b0;
        check("e2e dest_en count", destCount, 15);
        check("e2e payload sum", deliveredSum, 120);
        check("e2e nothing left pending", grantQ.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
